// File: rtl/fifo_pkg.sv
// Shared definitions for the 12-bit FIFO and its reader.
// Combinational only; no latency.
// No flow control of its own.
package fifo_pkg;

    localparam int DATA_SIZE = 12;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        DRAIN = ST_DRAIN
    } rd_state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order buffer absorbing the FIFO's registered read data.
// Latency: a push appears on head_dat/head_vld the following cycle when empty.
// Backpressure: head holds while pop is low; the caller never pushes when full.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = DATA_SIZE
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld
);

    logic [WIDTH-1:0] tail_dat;
    logic             do_pop;

    assign head_vld = (occ != 2'd0);
    assign do_pop   = pop && head_vld;

    // head_dat is left untouched when the last entry leaves, so data_out holds.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            occ      <= 2'd0;
            head_dat <= '0;
            tail_dat <= '0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_dat <= push_dat;
                        occ      <= 2'd1;
                    end else if (occ == 2'd1) begin
                        tail_dat <= push_dat;
                        occ      <= 2'd2;
                    end
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        head_dat <= tail_dat;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        head_dat <= tail_dat;
                        tail_dat <= push_dat;
                    end else begin
                        head_dat <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Drains the 12-bit FIFO in batches onto a valid/ready stream.
// Latency: read in cycle N gives valid_out in N+2 when the skid is empty.
// Backpressure: reads stop once skid plus in-flight words would exceed 2 entries.
module fifo_reader #(
    parameter int DATA_SIZE = fifo_pkg::DATA_SIZE,
    parameter int TIMEOUT   = 8,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic                 almost_empty,
    input  logic                 fifo_error,
    input  logic [DATA_SIZE-1:0] fifo_data_out,
    output logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [CNT_SIZE-1:0]  word_count,
    output logic                 rd_error
);
    import fifo_pkg::*;

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    rd_state_t       state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            inflight;
    logic            pop;
    logic [1:0]      occ;
    logic [2:0]      credit_used;
    logic            timed_out;

    assign pop         = valid_out && ready_in;
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign timed_out   = (wait_cnt == WC_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        read         = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_empty) begin
                    wait_cnt_nxt = '0;
                end else if (!timed_out) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
                if (enable && !fifo_empty && (!almost_empty || timed_out)) begin
                    state_nxt    = DRAIN;
                    wait_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                // A word leaving this cycle frees a slot for the read issued now.
                read         = enable && !fifo_empty && (credit_used < 3'd2 + {2'b00, pop});
                wait_cnt_nxt = '0;
                if (fifo_empty || !enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset_L) begin
            read = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            inflight   <= 1'b0;
            word_count <= '0;
            rd_error   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            inflight <= read;
            if (pop) begin
                word_count <= word_count + 1'b1;
            end
            if (fifo_error) begin
                rd_error <= 1'b1;
            end
        end
    end

    fifo_reader_skid #(
        .WIDTH (DATA_SIZE)
    ) u_skid (
        .clk      (clk),
        .reset_L  (reset_L),
        .push     (inflight),
        .push_dat (fifo_data_out),
        .pop      (pop),
        .occ      (occ),
        .head_dat (data_out),
        .head_vld (valid_out)
    );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO model feeding the DUT, scoreboard on the stream.
module tb_fifo_reader;
    localparam int DW = 12;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_L, enable, fifo_empty, almost_empty, fifo_error;
    logic [DW-1:0] fifo_data_out, data_out;
    logic          read, valid_out, ready_in, rd_error;
    logic [CW-1:0] word_count;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    int            pop_total;
    logic          err_m;

    logic          rd_s, pop_s, rst_s, vld_s, err_s, rderr_s, prev_hold;
    logic [DW-1:0] dat_s, prev_dat;
    logic [CW-1:0] wc_s;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_SIZE(DW), .TIMEOUT(TO), .CNT_SIZE(CW)) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .almost_empty  (almost_empty),
        .fifo_error    (fifo_error),
        .fifo_data_out (fifo_data_out),
        .read          (read),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .word_count    (word_count),
        .rd_error      (rd_error)
    );

    task automatic upd_flags();
        fifo_empty   = (fq.size() == 0);
        almost_empty = (fq.size() <= 1);
    endtask

    task automatic load_seq(input int n, input int base);
        for (int i = 0; i < n; i++) fq.push_back(DW'(base + i));
        upd_flags();
    endtask

    // One clock: sample and check at negedge, then advance the FIFO and stream models.
    task automatic cycle();
        logic [DW-1:0] w;
        @(negedge clk);
        rd_s = read; vld_s = valid_out; pop_s = valid_out && ready_in; rst_s = reset_L;
        dat_s = data_out; wc_s = word_count; err_s = fifo_error; rderr_s = rd_error;
        checks++;
        if (rd_s && fifo_empty) begin
            errors++; $display("FAIL read_when_empty: read=%b fifo_empty=%b, want read=0", rd_s, fifo_empty);
        end
        checks++;
        if (wc_s !== CW'(pop_total)) begin
            errors++; $display("FAIL word_count: got %0d, want %0d", wc_s, CW'(pop_total));
        end
        checks++;
        if (rderr_s !== err_m) begin
            errors++; $display("FAIL rd_error: got %b, want %b", rderr_s, err_m);
        end
        checks++;
        if (exp_q.size() > 2) begin
            errors++; $display("FAIL outstanding: got %0d words read but undelivered, want <=2", exp_q.size());
        end
        if (prev_hold) begin
            checks++;
            if (vld_s !== 1'b1 || dat_s !== prev_dat) begin
                errors++; $display("FAIL hold: valid=%b data=%h, want valid=1 data=%h", vld_s, dat_s, prev_dat);
            end
        end
        if (rst_s && pop_s) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL spurious_word: got %h, want no word", dat_s);
            end else begin
                w = exp_q.pop_front();
                if (dat_s !== w) begin
                    errors++; $display("FAIL stream_order: got %h, want %h", dat_s, w);
                end
            end
            pop_total++;
        end
        prev_hold = rst_s && vld_s && !ready_in;
        prev_dat  = dat_s;
        @(posedge clk);
        #1;
        if (!rst_s) begin
            exp_q.delete(); pop_total = 0; err_m = 1'b0;
        end else if (err_s) begin
            err_m = 1'b1;
        end
        if (rd_s && fq.size() > 0) begin
            w = fq.pop_front();
            fifo_data_out = w;
            if (rst_s) exp_q.push_back(w);
        end else begin
            fifo_data_out = DW'($urandom);
        end
        upd_flags();
    endtask

    task automatic drain_all(input int bound);
        int n = 0;
        enable = 1'b1; ready_in = 1'b1;
        while ((fq.size() != 0 || exp_q.size() != 0) && n < bound) begin
            cycle(); n++;
        end
        checks++;
        if (n >= bound) begin
            errors++; $display("FAIL drain_timeout: %0d words left after %0d cycles, want 0", fq.size() + exp_q.size(), n);
        end
        repeat (2) cycle();
    endtask

    task automatic test_reset();
        load_seq(5, 'h010);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (rd_s !== 1'b0 || vld_s !== 1'b0 || dat_s !== '0 || wc_s !== '0) begin
                errors++; $display("FAIL reset_state: read=%b valid=%b data=%h count=%0d, want all 0", rd_s, vld_s, dat_s, wc_s);
            end
        end
        reset_L = 1'b1;
        cycle();
        checks++;
        if (rd_s !== 1'b0) begin
            errors++; $display("FAIL reset_release_read: got %b, want 0", rd_s);
        end
        cycle();
        checks++;
        if (rd_s !== 1'b1) begin
            errors++; $display("FAIL first_read_after_reset: got %b, want 1", rd_s);
        end
        drain_all(60);
    endtask

    task automatic test_burst();
        int first_rd = -1, last_rd = -1, nrd = 0, npop = 0, base;
        base = pop_total;
        load_seq(6, 1);
        for (int t = 0; t < 12; t++) begin
            cycle();
            if (rd_s) begin
                if (first_rd < 0) first_rd = t;
                last_rd = t; nrd++;
            end
            if (pop_s) begin
                checks++;
                if (t != first_rd + 2 + npop || dat_s !== DW'(npop + 1)) begin
                    errors++; $display("FAIL burst_timing: cycle %0d data %h, want cycle %0d data %h", t, dat_s, first_rd + 2 + npop, npop + 1);
                end
                npop++;
            end
        end
        checks++;
        if (first_rd != 1 || nrd != 6 || last_rd - first_rd != 5) begin
            errors++; $display("FAIL burst_reads: first=%0d count=%0d span=%0d, want 1/6/5", first_rd, nrd, last_rd - first_rd);
        end
        checks++;
        if (npop != 6 || word_count !== CW'(base + 6)) begin
            errors++; $display("FAIL burst_count: pops=%0d word_count=%0d, want 6/%0d", npop, word_count, base + 6);
        end
    endtask

    task automatic test_timeout();
        int first_rd = -1, nrd = 0, npop = 0;
        fq.push_back(DW'('h0AB)); upd_flags();
        for (int t = 0; t < 16; t++) begin
            cycle();
            if (rd_s) begin
                if (first_rd < 0) first_rd = t;
                nrd++;
            end
            if (pop_s) begin
                checks++;
                if (dat_s !== DW'('h0AB) || t != first_rd + 2) begin
                    errors++; $display("FAIL timeout_data: got %h at %0d, want 0ab at %0d", dat_s, t, first_rd + 2);
                end
                npop++;
            end
        end
        checks++;
        if (first_rd != TO || nrd != 1 || npop != 1) begin
            errors++; $display("FAIL timeout_read: first=%0d reads=%0d pops=%0d, want %0d/1/1", first_rd, nrd, npop, TO);
        end
    endtask

    task automatic test_backpressure();
        int nrd = 0, npop = 0;
        load_seq(6, 1);
        for (int t = 0; t < 20; t++) begin
            ready_in = !(t >= 3 && t <= 5);
            cycle();
            if (rd_s) nrd++;
            if (t >= 3 && t <= 5) begin
                checks++;
                if (rd_s !== 1'b0) begin
                    errors++; $display("FAIL bp_read_suppress: cycle %0d read=%b, want 0", t, rd_s);
                end
            end
            if (pop_s) npop++;
        end
        ready_in = 1'b1;
        checks++;
        if (nrd != 6 || npop != 6) begin
            errors++; $display("FAIL bp_totals: reads=%0d pops=%0d, want 6/6", nrd, npop);
        end
    endtask

    task automatic test_enable_drop();
        int nrd_before = 0, nrd = 0, npop_off = 0, npop = 0;
        load_seq(6, 1);
        for (int t = 0; t < 20; t++) begin
            enable = !(t >= 3 && t <= 8);
            cycle();
            if (rd_s) begin
                nrd++;
                if (t < 3) nrd_before++;
            end
            if (pop_s) begin
                npop++;
                if (t <= 8) npop_off++;
            end
            if (t >= 3 && t <= 8) begin
                checks++;
                if (rd_s !== 1'b0) begin
                    errors++; $display("FAIL en_drop_read: cycle %0d read=%b, want 0", t, rd_s);
                end
            end
        end
        checks++;
        if (nrd_before != 2 || npop_off != 2 || nrd != 6 || npop != 6) begin
            errors++; $display("FAIL en_drop_totals: pre=%0d delivered_off=%0d reads=%0d pops=%0d, want 2/2/6/6", nrd_before, npop_off, nrd, npop);
        end
    endtask

    task automatic test_error_and_reset();
        int npop = 0;
        load_seq(4, 'h021);
        for (int t = 0; t < 12; t++) begin
            fifo_error = (t == 2);
            cycle();
            if (pop_s) npop++;
            if (t == 2 || t >= 3) begin
                checks++;
                if (rderr_s !== (t >= 3)) begin
                    errors++; $display("FAIL err_sticky: cycle %0d rd_error=%b, want %b", t, rderr_s, (t >= 3));
                end
            end
        end
        fifo_error = 1'b0;
        checks++;
        if (npop != 4) begin
            errors++; $display("FAIL err_flow: pops=%0d, want 4", npop);
        end
        load_seq(8, 'h100);
        repeat (4) cycle();
        reset_L = 1'b0;
        repeat (2) cycle();
        checks++;
        if (vld_s !== 1'b0 || wc_s !== '0 || rderr_s !== 1'b0 || rd_s !== 1'b0) begin
            errors++; $display("FAIL midburst_reset: valid=%b count=%0d rd_error=%b read=%b, want all 0", vld_s, wc_s, rderr_s, rd_s);
        end
        reset_L = 1'b1;
        drain_all(80);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if (fq.size() < 10 && $urandom_range(0, 99) < 35) begin
                fq.push_back(DW'($urandom)); upd_flags();
            end
            ready_in   = ($urandom_range(0, 99) < 70);
            enable     = ($urandom_range(0, 99) < 90);
            fifo_error = ($urandom_range(0, 199) == 0);
            cycle();
        end
        fifo_error = 1'b0;
        drain_all(200);
    endtask

    initial begin
        reset_L = 1'b0; enable = 1'b1; ready_in = 1'b1; fifo_error = 1'b0;
        fifo_data_out = '0; pop_total = 0; err_m = 1'b0; prev_hold = 1'b0; prev_dat = '0;
        upd_flags();
        test_reset();
        test_burst();
        test_timeout();
        test_backpressure();
        test_enable_drop();
        test_error_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
